// File: rtl/gcd_host_sequencer.sv
// Host-side sequencer for the subtraction GCD core: operand handshake, core load sequence, result return.
// Optional watchdog on the WAIT state is enabled by defining GCD_HOST_TIMEOUT_EN.
`timescale 1ns/1ps

module gcd_host_sequencer #(
  parameter int unsigned WIDTH          = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_gcd,
  output logic             out_bypass,
  output logic             out_err,
  output logic             busy,
  output logic             core_clr,
  output logic             core_start,
  output logic [WIDTH-1:0] core_data,
  input  logic             core_done,
  input  logic [WIDTH-1:0] core_result
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLR    = 3'd1,
    S_LOAD_A = 3'd2,
    S_LOAD_B = 3'd3,
    S_WAIT   = 3'd4,
    S_RESP   = 3'd5
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] gcd_q;
  logic             bypass_q;
  logic             accept;
  logic             zero_op;
  logic             expire;

  assign accept  = in_valid & (state == S_IDLE);
  // A zero operand would spin the subtraction loop forever; answer it locally.
  assign zero_op = (in_a == '0) | (in_b == '0);

`ifdef GCD_HOST_TIMEOUT_EN
  localparam int unsigned WDOG_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WDOG_W-1:0] wdog;
  logic              err_q;

  // Watchdog: held at zero outside WAIT, counts each WAIT cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wdog <= '0;
    end else if (state != S_WAIT) begin
      wdog <= '0;
    end else begin
      wdog <= wdog + WDOG_W'(1);
    end
  end

  // Expiry is the last WAIT cycle; depends on registered state only.
  assign expire = (state == S_WAIT) && (wdog == WDOG_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (accept) begin
      err_q <= 1'b0;
    end else if (expire && !core_done) begin
      err_q <= 1'b1;
    end
  end

  assign out_err = err_q;
`else
  assign expire  = 1'b0;
  assign out_err = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (in_valid) state_nx = zero_op ? S_RESP : S_CLR;
      S_CLR:    state_nx = S_LOAD_A;
      S_LOAD_A: state_nx = S_LOAD_B;
      S_LOAD_B: state_nx = S_WAIT;
      S_WAIT:   if (core_done || expire) state_nx = S_RESP;
      S_RESP:   if (out_ready) state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  // Outputs decoded from registered state and operand registers only
  always_comb begin
    in_ready   = 1'b0;
    busy       = 1'b1;
    out_valid  = 1'b0;
    core_clr   = 1'b0;
    core_start = 1'b0;
    core_data  = '0;
    case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
      end
      S_CLR:    core_clr = 1'b1;
      S_LOAD_A: begin
        core_start = 1'b1;
        core_data  = a_q;
      end
      S_LOAD_B: core_data = b_q;
      S_WAIT: begin
        core_data = b_q;
        core_clr  = expire;
      end
      S_RESP:   out_valid = 1'b1;
      default:  busy = 1'b1;
    endcase
  end

  // Operand and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      gcd_q    <= '0;
      bypass_q <= 1'b0;
    end else if (accept) begin
      a_q      <= in_a;
      b_q      <= in_b;
      gcd_q    <= zero_op ? (in_a | in_b) : '0;
      bypass_q <= zero_op;
    end else if (state == S_WAIT) begin
      if (core_done) begin
        gcd_q <= core_result;
      end else if (expire) begin
        gcd_q <= '0;
      end
    end
  end

  assign out_gcd    = gcd_q;
  assign out_bypass = bypass_q;

endmodule
